nfc_page_reader: RTL

//  Source-side flash interface of NFC: on start, issues a small-page READ (00h) to flash A,

---
 rtl/nfc_page_reader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/nfc_page_reader.sv
// Source-side flash reader: issues a small-page READ (00h) to flash A, waits out tWB and busy,
// then strobes RE# once per byte and streams the page out on a valid/ready byte interface.
module nfc_page_reader #(
    parameter int PAGE_BYTES = 512,
    parameter int PAGE_AW    = 9,
    parameter int WB_CYC     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PAGE_AW-1:0] page_addr,
    output logic               busy,
    output logic               done,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    inout  wire  [7:0]         F_IO,
    output logic               F_CLE,
    output logic               F_ALE,
    output logic               F_WEN,
    output logic               F_REN,
    input  logic               F_RB
);

    localparam int IDX_W = $clog2(PAGE_BYTES) + 1;
    localparam int WB_W  = $clog2(WB_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAGE_BYTES - 1);
    localparam logic [WB_W-1:0]  WB_LAST  = WB_W'(WB_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, CMD, ADR0, ADR1, ADR2, TWB, WRDY, RD_LO, RD_HI, PUSH, FIN
    } state_t;

    state_t             state_q, state_d;
    logic               phase_q;
    logic [WB_W-1:0]    wb_cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [PAGE_AW-1:0] page_q;
    logic [15:0]        page_ext;
    logic               io_oe;
    logic [7:0]         io_byte;
    logic               bus_state;

    assign page_ext  = 16'(page_q);
    assign bus_state = (state_q == CMD) || (state_q == ADR0) ||
                       (state_q == ADR1) || (state_q == ADR2);
    assign F_IO      = io_oe ? io_byte : 8'hzz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // phase_q: 0 = WE# low half of a bus write cycle, 1 = WE# high half
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= 1'b0;
            wb_cnt_q <= '0;
            idx_q    <= '0;
        end else begin
            phase_q  <= bus_state ? ~phase_q : 1'b0;
            wb_cnt_q <= (state_q == TWB) ? wb_cnt_q + WB_W'(1) : '0;
            if (state_q == IDLE) begin
                idx_q <= '0;
            end else if (state_q == PUSH && out_ready) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= 8'h00;
        end else if (state_q == RD_LO) begin
            out_data <= F_IO;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            page_q <= page_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CMD;
            CMD:     if (phase_q) state_d = ADR0;
            ADR0:    if (phase_q) state_d = ADR1;
            ADR1:    if (phase_q) state_d = ADR2;
            ADR2:    if (phase_q) state_d = TWB;
            TWB:     if (wb_cnt_q == WB_LAST) state_d = WRDY;
            WRDY:    if (F_RB) state_d = RD_LO;
            RD_LO:   state_d = RD_HI;
            RD_HI:   state_d = PUSH;
            PUSH:    if (out_ready) state_d = (idx_q == LAST_IDX) ? FIN : RD_LO;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        F_CLE     = 1'b0;
        F_ALE     = 1'b0;
        F_WEN     = 1'b1;
        F_REN     = 1'b1;
        io_oe     = 1'b0;
        io_byte   = 8'h00;
        busy      = (state_q != IDLE);
        done      = (state_q == FIN);
        out_valid = (state_q == PUSH);
        out_last  = (state_q == PUSH) && (idx_q == LAST_IDX);
        case (state_q)
            CMD: begin
                F_CLE = 1'b1;
                F_WEN = phase_q;
                io_oe = 1'b1;
            end
            ADR0: begin
                F_ALE = 1'b1;
                F_WEN = phase_q;
                io_oe = 1'b1;
            end
            ADR1: begin
                F_ALE   = 1'b1;
                F_WEN   = phase_q;
                io_oe   = 1'b1;
                io_byte = page_ext[7:0];
            end
            ADR2: begin
                F_ALE   = 1'b1;
                F_WEN   = phase_q;
                io_oe   = 1'b1;
                io_byte = page_ext[15:8];
            end
            RD_LO:   F_REN = 1'b0;
            default: ;
        endcase
    end

endmodule
